// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: segment patterns,
// scan state encoding and the blank cathode value.
package ssd_pkg;

  // Scan FSM states.
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } scan_state_e;

  // All cathodes high: every segment and the dp are dark.
  localparam logic [7:0] SSD_BLANK = 8'hFF;

  // Active-low segment patterns g..a, indexed by hex nibble (entry 15 is MSB).
  localparam logic [15:0][6:0] SEG_PATTERNS = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // D
    7'b0100111,  // C
    7'b0000011,  // B
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Bundle between the lab datapath (master) and the scan controller (slave):
// scan enable, digit write port and the pin-facing display outputs.
interface ssd_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
) ();

  localparam int AW = $clog2(NUM_DIGITS);

  logic                  En;
  logic                  WrEn;
  logic [AW-1:0]         WrAddr;
  logic [4:0]            WrData;
  logic [7:0]            SSD;
  logic [NUM_DIGITS-1:0] AN;
  logic [AW-1:0]         DigitIdx;
  logic                  FrameTick;

  modport master (
    output En, WrEn, WrAddr, WrData,
    input  SSD, AN, DigitIdx, FrameTick
  );

  modport slave (
    input  En, WrEn, WrAddr, WrData,
    output SSD, AN, DigitIdx, FrameTick
  );

endinterface

// File: rtl/ssd_scan_ctrl_hex_decode.sv
// Combinational {dp, nibble} to active-low cathode pattern.
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [4:0] val_i,
  output logic [7:0] ssd_o
);

  // dp is active-low on the pin, so a lit dp drives SSD[7] low.
  assign ssd_o = {~val_i[4], SEG_PATTERNS[val_i[3:0]]};

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed scan controller: per-digit value registers, a slot
// counter walking DRIVE/GAP phases for each digit, one shared decoder and
// registered anode/cathode outputs.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 16
) (
  input logic            Clk,
  input logic            Rst_n,
  ssd_scan_ctrl_if.slave bus
);

  localparam int AW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);

  // Last counter value of the lit phase and of the whole slot.
  localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - GAP_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIGITS - 1);

  scan_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic                  tick_q, tick_d;

  logic [4:0]            digit_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] wr_hit;
  logic [NUM_DIGITS-1:0] an_sel;
  logic [4:0]            cur_digit;
  logic [7:0]            dec_ssd;

  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            ssd_q, ssd_d;

  // One-hot write decode; addresses beyond the last digit match no entry
  // and so are dropped. Also the active-low anode pattern for idx_q.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign wr_hit[gi] = bus.WrEn && (bus.WrAddr == AW'(gi));
    assign an_sel[gi] = (idx_q != AW'(gi));
  end

  // Digit register file; writes land regardless of scan state.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!Rst_n) begin
        digit_q[i] <= '0;
      end else if (wr_hit[i]) begin
        digit_q[i] <= bus.WrData;
      end
    end
  end

  // Decode straight from the live register so a write to the shown digit
  // appears on the next edge.
  assign cur_digit = digit_q[idx_q];

  ssd_hex_decode u_dec (
    .val_i (cur_digit),
    .ssd_o (dec_ssd)
  );

  // Scan state, slot counter, digit index and frame pulse registers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
    end
  end

  // Next-state logic; a low enable forces OFF over every other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tick_d  = 1'b0;
    case (state_q)
      ST_OFF: begin
        cnt_d = '0;
        idx_d = '0;
        state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DRIVE_LAST) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == SLOT_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d  = '0;
            tick_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
    if (!bus.En) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      idx_d   = '0;
      tick_d  = 1'b0;
    end
  end

  // Pin values for the current state; anode and cathodes are derived from
  // the same state so a pattern never meets the wrong anode.
  always_comb begin
    an_d  = '1;
    ssd_d = SSD_BLANK;
    if (state_q == ST_DRIVE) begin
      an_d  = an_sel;
      ssd_d = dec_ssd;
    end
  end

  // Output registers for anodes and cathodes.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      an_q  <= '1;
      ssd_q <= SSD_BLANK;
    end else begin
      an_q  <= an_d;
      ssd_q <= ssd_d;
    end
  end

  assign bus.AN        = an_q;
  assign bus.SSD       = ssd_q;
  assign bus.DigitIdx  = idx_q;
  assign bus.FrameTick = tick_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl: a 4-digit instance and a 3-digit
// instance, both with an 8-cycle slot and a 2-cycle blanking gap.
module tb_ssd_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_asserts = 0;
  int   n_fails   = 0;
  int   t_a, t_b;
  logic [7:0] tbl_a [4];
  logic [7:0] tbl_b [3];

  always #5 clk = ~clk;

  ssd_scan_ctrl_if #(.NUM_DIGITS(4)) abus ();
  ssd_scan_ctrl_if #(.NUM_DIGITS(3)) bbus ();

  ssd_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GAP_CYCLES(2)) dut_a (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (abus)
  );

  ssd_scan_ctrl #(.NUM_DIGITS(3), .REFRESH_DIV(8), .GAP_CYCLES(2)) dut_b (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bbus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // t = edges since the enable edge; DRIVE lit for slot positions 0..5.
  function automatic logic [31:0] exp_an(input int n, input int t);
    logic [31:0] mask;
    int slot, pos;
    mask = (32'h1 << n) - 32'h1;
    slot = ((t - 1) / 8) % n;
    pos  = (t - 1) % 8;
    if (pos < 6) return mask & ~(32'h1 << slot);
    return mask;
  endfunction

  task automatic step_a();
    int slot;
    tick();
    t_a++;
    slot = ((t_a - 1) / 8) % 4;
    chk($sformatf("A_AN t=%0d", t_a), 32'(abus.AN), exp_an(4, t_a));
    chk($sformatf("A_SSD t=%0d", t_a), 32'(abus.SSD),
        (((t_a - 1) % 8) < 6) ? 32'(tbl_a[slot]) : 32'hFF);
    chk($sformatf("A_IDX t=%0d", t_a), 32'(abus.DigitIdx), 32'((t_a / 8) % 4));
    chk($sformatf("A_TICK t=%0d", t_a), 32'(abus.FrameTick), (t_a % 32 == 0) ? 32'd1 : 32'd0);
    $display("A t=%0d AN=%b SSD=%h IDX=%0d TICK=%b", t_a, abus.AN, abus.SSD, abus.DigitIdx, abus.FrameTick);
  endtask

  task automatic step_b();
    int slot;
    tick();
    t_b++;
    slot = ((t_b - 1) / 8) % 3;
    chk($sformatf("B_AN t=%0d", t_b), 32'(bbus.AN), exp_an(3, t_b));
    chk($sformatf("B_SSD t=%0d", t_b), 32'(bbus.SSD),
        (((t_b - 1) % 8) < 6) ? 32'(tbl_b[slot]) : 32'hFF);
    chk($sformatf("B_IDX t=%0d", t_b), 32'(bbus.DigitIdx), 32'((t_b / 8) % 3));
    chk($sformatf("B_TICK t=%0d", t_b), 32'(bbus.FrameTick), (t_b % 24 == 0) ? 32'd1 : 32'd0);
    $display("B t=%0d AN=%b SSD=%h IDX=%0d TICK=%b", t_b, bbus.AN, bbus.SSD, bbus.DigitIdx, bbus.FrameTick);
  endtask

  initial begin
    rst_n       = 1'b0;
    abus.En     = 1'b0;
    abus.WrEn   = 1'b0;
    abus.WrAddr = '0;
    abus.WrData = '0;
    bbus.En     = 1'b0;
    bbus.WrEn   = 1'b0;
    bbus.WrAddr = '0;
    bbus.WrData = '0;
    tbl_a = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
    tbl_b = '{8'hF9, 8'hA4, 8'hB0};

    // Reset state, with En high during reset to show reset wins.
    tick();
    abus.En = 1'b1;
    tick();
    tick();
    chk("RST_A_AN", 32'(abus.AN), 32'hF);
    chk("RST_A_SSD", 32'(abus.SSD), 32'hFF);
    chk("RST_A_IDX", 32'(abus.DigitIdx), 32'd0);
    chk("RST_A_TICK", 32'(abus.FrameTick), 32'd0);
    chk("RST_B_AN", 32'(bbus.AN), 32'h7);
    chk("RST_B_SSD", 32'(bbus.SSD), 32'hFF);
    $display("reset AN=%b SSD=%h", abus.AN, abus.SSD);
    abus.En = 1'b0;
    rst_n   = 1'b1;

    // Test 1: digits 1,2,3,4 then enable; one full frame plus a slot.
    for (int i = 0; i < 4; i++) begin
      abus.WrEn   = 1'b1;
      abus.WrAddr = 2'(i);
      abus.WrData = 5'(i + 1);
      tick();
      $display("A write addr=%0d data=%h", i, 5'(i + 1));
    end
    abus.WrEn = 1'b0;
    abus.En   = 1'b1;
    tick();
    t_a = 0;
    chk("A_EN_LAT_AN", 32'(abus.AN), 32'hF);
    chk("A_EN_LAT_IDX", 32'(abus.DigitIdx), 32'd0);
    while (t_a < 40) step_a();

    // Test 2: digit 2 = dp + A.
    abus.WrEn   = 1'b1;
    abus.WrAddr = 2'd2;
    abus.WrData = 5'h1A;
    step_a();
    abus.WrEn = 1'b0;
    tbl_a[2]  = 8'h08;
    while (t_a < 66) step_a();

    // Test 3: rewrite digit 0 while it is lit; change shows one edge later.
    abus.WrEn   = 1'b1;
    abus.WrAddr = 2'd0;
    abus.WrData = 5'h08;
    step_a();
    abus.WrEn = 1'b0;
    tbl_a[0]  = 8'h80;
    while (t_a < 94) step_a();

    // Test 4: drop En for one cycle in the gap of digit 3.
    abus.En = 1'b0;
    tick();
    chk("T4_DARK_AN", 32'(abus.AN), 32'hF);
    chk("T4_DARK_SSD", 32'(abus.SSD), 32'hFF);
    chk("T4_DARK_TICK", 32'(abus.FrameTick), 32'd0);
    $display("T4 En low AN=%b SSD=%h", abus.AN, abus.SSD);
    abus.En = 1'b1;
    tick();
    chk("T4_RESTART_AN", 32'(abus.AN), 32'hF);
    chk("T4_RESTART_TICK", 32'(abus.FrameTick), 32'd0);
    chk("T4_RESTART_IDX", 32'(abus.DigitIdx), 32'd0);
    $display("T4 restart AN=%b TICK=%b", abus.AN, abus.FrameTick);
    t_a = 0;
    while (t_a < 10) step_a();

    // Test 5: one-cycle reset during DRIVE of digit 1 with a write pending.
    rst_n       = 1'b0;
    abus.WrEn   = 1'b1;
    abus.WrAddr = 2'd1;
    abus.WrData = 5'h1F;
    tick();
    chk("T5_RST_AN", 32'(abus.AN), 32'hF);
    chk("T5_RST_SSD", 32'(abus.SSD), 32'hFF);
    chk("T5_RST_IDX", 32'(abus.DigitIdx), 32'd0);
    chk("T5_RST_TICK", 32'(abus.FrameTick), 32'd0);
    $display("T5 reset AN=%b SSD=%h IDX=%0d", abus.AN, abus.SSD, abus.DigitIdx);
    rst_n     = 1'b1;
    abus.WrEn = 1'b0;
    tick();
    t_a = 0;
    chk("T5_REEN_AN", 32'(abus.AN), 32'hF);
    tbl_a = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
    while (t_a < 33) step_a();

    // Test 6: 3-digit instance, out-of-range write to address 3.
    for (int i = 0; i < 4; i++) begin
      bbus.WrEn   = 1'b1;
      bbus.WrAddr = 2'(i);
      bbus.WrData = (i == 3) ? 5'h05 : 5'(i + 1);
      tick();
      $display("B write addr=%0d data=%h", i, bbus.WrData);
    end
    bbus.WrEn = 1'b0;
    bbus.En   = 1'b1;
    tick();
    t_b = 0;
    chk("B_EN_LAT_AN", 32'(bbus.AN), 32'h7);
    while (t_b < 26) step_b();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
# ssd_scan_ctrl

Time-multiplexed seven-segment scan controller. It holds one 5-bit value per digit: a hex nibble plus a decimal-point bit. It cycles one shared hex decoder across NUM_DIGITS common-anode digits, with a blanking gap between digits to suppress ghosting. The block sits between the lab datapath, which writes digit values, and the board's SSD cathode and anode pins.

## Interface
Parameters:
- NUM_DIGITS, 4: number of multiplexed digits, 2..8.
- REFRESH_DIV, 50000: clock cycles per digit slot.
- GAP_CYCLES, 16: blanked cycles at the end of each slot. Must satisfy 1 ≤ GAP_CYCLES < REFRESH_DIV.

Ports:
- Clk, input, 1: system clock. One clock domain. Reset is synchronous and active-low.
- Rst_n, input, 1: synchronous active-low reset, sampled on the Clk rising edge.
- En, input, 1: scan enable. When low, the display is dark.
- WrEn, input, 1: write strobe for the digit register file.
- WrAddr, input, clog2(NUM_DIGITS): digit index to write. Index 0 is the rightmost digit.
- WrData, input, 5: bit 4 is dp (1 = lit); bits 3:0 are the hex value.
- SSD, output, 8: active-low cathodes. SSD[6:0] is segments g..a. SSD[7] = ~dp.
- AN, output, NUM_DIGITS: active-low anodes. At most one bit is low at any time.
- DigitIdx, output, clog2(NUM_DIGITS): index of the current slot.
- FrameTick, output, 1: one-cycle pulse when the scan wraps from the last digit back to digit 0.

## Operation
- Digit register file: NUM_DIGITS × 5 bits.
  - When WrEn=1, the entry at WrAddr is written on the clock edge.
  - A WrAddr ≥ NUM_DIGITS is ignored.
  - Writes are never blocked.
- FSM states:
  - OFF: AN all ones, SSD = 8'hFF, slot counter = 0, index = 0.
  - DRIVE: AN[idx] low; SSD = decode(reg[idx]).
  - GAP: AN all ones; SSD = 8'hFF.
- Transitions:
  - OFF → DRIVE when En=1.
  - DRIVE → GAP when the slot counter reaches REFRESH_DIV−GAP_CYCLES−1.
  - GAP → DRIVE when the slot counter reaches REFRESH_DIV−1. On this transition the counter clears, idx increments, and idx wraps from NUM_DIGITS−1 to 0.
  - Any state → OFF when En=0. This takes priority over all other transitions.
- Decode, nibble 0..F, as SSD[6:0]:
  - 0–7: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000.
  - 8–F: 0000000, 0010000, 0001000, 0000011, 0100111, 0100001, 0000110, 0001110.
- Decode is evaluated from the live register every cycle in DRIVE, so a write to the currently displayed digit appears without waiting for the next frame.
- FrameTick is asserted with the GAP→DRIVE transition that wraps idx to 0.

## Timing
- All outputs are registered.
- Reset values: AN all ones, SSD 8'hFF, DigitIdx 0, FrameTick 0, state OFF, slot counter 0, all digit registers 5'h00.
- Reset mid-scan: on the first edge with Rst_n=0, everything returns to the reset values. Reset overrides En and WrEn in the same cycle.
- Enable latency:
  - En sampled high at edge k gives AN = ~(1<<0) and a valid SSD after edge k+1.
  - En sampled low at edge k gives dark outputs after edge k+1.
  - Re-enabling always restarts at digit 0 with a fresh slot.
- Per slot: AN[idx] is low for exactly REFRESH_DIV−GAP_CYCLES cycles, then all ones for exactly GAP_CYCLES cycles. The frame period is NUM_DIGITS×REFRESH_DIV cycles.
- DigitIdx changes on the same edge that the next DRIVE begins.
- Write latency: a write at edge k affects SSD from edge k+1 if that digit is being driven.
- Same-cycle write and slot change: the new slot displays the newly written value.
- AN and SSD change together. A non-blank SSD pattern is never presented with the wrong anode.

## Structure
- The shared package `ssd_pkg` holds:
  - the 16-entry segment pattern constants;
  - the state encoding (OFF=2'd0, DRIVE=2'd1, GAP=2'd2);
  - the SSD_BLANK = 8'hFF constant.
- Sub-module `ssd_hex_decode` is a purely combinational mapping of {dp, nibble} to SSD[7:0]. The scan controller instantiates it once and registers its output.
- Slot counter width is clog2(REFRESH_DIV).

## Test plan
Benches use NUM_DIGITS=4, REFRESH_DIV=8, GAP_CYCLES=2 unless noted.
1. Reset then En=1, with registers written to 1,2,3,4 → AN sequence 1110 ×6, 1111 ×2, 1101 ×6, 1111 ×2, and so on. SSD on digit 0 = 8'hF9. FrameTick fires once every 32 cycles.
2. Write WrData=5'h1A to digit 2 → in slot 2, SSD = 8'h08 (dp lit, segment pattern A).
3. Write digit 0 = 5'h08 mid-DRIVE of digit 0 → SSD changes from the old value to 8'h80 one cycle later. AN stays unchanged.
4. Drop En mid-GAP of digit 3 for 1 cycle, then raise it → outputs go dark. The scan restarts at digit 0 with a full 6-cycle DRIVE, and there is no FrameTick on the restart.
5. Assert Rst_n=0 for 1 cycle during DRIVE of digit 1, with WrEn=1 in the same cycle → all reset values, the write is discarded, and every register reads 0 (display shows "0000" after re-enable).
6. Sweep WrAddr=3 with NUM_DIGITS=3 → the write is ignored, AN width is 3, and idx wraps from 2 to 0.
